// File: rtl/nn_pkg.sv
// Shared constants and state encoding for the sequential neuron MAC.
package nn_pkg;

  localparam int DATA_W   = 16;
  localparam int FRAC_W   = 8;
  localparam int N_INPUTS = 28;
  localparam int ADDR_W   = 5;
  // Q16.16 products summed over 28 terms need 5 guard bits above 32.
  localparam int ACC_W    = 37;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } nn_state_e;

endpackage

// File: rtl/q_saturate.sv
// Converts the wide Q.16 accumulator sum back to Q8.8: arithmetic shift
// right (floor), saturation to the signed output range, optional ReLU.
module q_saturate #(
  parameter int DATA_W = nn_pkg::DATA_W,
  parameter int FRAC_W = nn_pkg::FRAC_W,
  parameter int ACC_W  = nn_pkg::ACC_W,
  parameter int RELU   = 1
) (
  input  logic signed [ACC_W-1:0]  sum,
  output logic        [DATA_W-1:0] q
);
  import nn_pkg::*;

  localparam int SH_W = ACC_W - FRAC_W;
  localparam logic signed [SH_W-1:0] MAX_Q = SH_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [SH_W-1:0] MIN_Q = SH_W'(-(2 ** (DATA_W - 1)));

  logic signed [SH_W-1:0] shifted;

  // Floor division by 2^FRAC_W; the shift cannot lose meaningful high bits.
  assign shifted = SH_W'(sum >>> FRAC_W);

  // Clamp to the representable range, then zero negative results if ReLU.
  always_comb begin
    q = shifted[DATA_W-1:0];
    if (shifted > MAX_Q) begin
      q = {1'b0, {(DATA_W - 1){1'b1}}};
    end else if (shifted < MIN_Q) begin
      q = {1'b1, {(DATA_W - 1){1'b0}}};
    end
    if ((RELU != 0) && shifted[SH_W-1]) begin
      q = '0;
    end
  end

endmodule

// File: rtl/neuron_mac_seq.sv
// Sequential single-neuron evaluator. Streams N_INPUTS weight/activation
// pairs from two BRAMs sharing one address, multiplies in a registered
// stage, accumulates in a second stage, then adds bias and quantizes.
//
// Timeline relative to the edge that accepts START (edge 0):
//   edges 0..27  : ADDR = 0..27 with EN = 1
//   edges 1..28  : product register captures pair ADDR-1
//   edges 2..29  : accumulator adds the product
//   edge 30      : Y registered from ACC + BIAS, DONE pulses, BUSY drops
// Handshake: START is a single-cycle request honoured only while IDLE;
// DONE is a single-cycle strobe meaning Y is valid, and Y then holds
// until the next DONE. There is no backpressure on either side.
module neuron_mac_seq #(
  parameter int N_INPUTS = nn_pkg::N_INPUTS,
  parameter int DATA_W   = nn_pkg::DATA_W,
  parameter int FRAC_W   = nn_pkg::FRAC_W,
  parameter int RELU     = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      START,
  output logic [nn_pkg::ADDR_W-1:0] ADDR,
  output logic                      EN,
  output logic                      WE,
  input  logic [DATA_W-1:0]         W_DO,
  input  logic [DATA_W-1:0]         X_DO,
  input  logic [DATA_W-1:0]         BIAS,
  output logic [DATA_W-1:0]         Y,
  output logic                      BUSY,
  output logic                      DONE,
  output nn_pkg::nn_state_e         STATE_DBG
);
  import nn_pkg::*;

  localparam int PROD_W = 2 * DATA_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_INPUTS - 1);

  nn_state_e                 state;
  logic                      drain_cnt;
  logic                      p_vld;
  logic signed [DATA_W-1:0]  w_s;
  logic signed [DATA_W-1:0]  x_s;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   sum;
  logic        [DATA_W-1:0]  y_next;

  assign WE        = 1'b0;
  assign STATE_DBG = state;
  assign w_s       = W_DO;
  assign x_s       = X_DO;

  // Bias is Q8.8; align it with the Q.16 accumulator before adding.
  assign sum = acc + (ACC_W'(signed'(BIAS)) <<< FRAC_W);

  q_saturate #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ACC_W  (ACC_W),
    .RELU   (RELU)
  ) u_sat (
    .sum (sum),
    .q   (y_next)
  );

  // Control FSM: address sequencing, drain wait, result capture and flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      ADDR      <= '0;
      EN        <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      Y         <= '0;
      drain_cnt <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            state <= ST_RUN;
            ADDR  <= '0;
            EN    <= 1'b1;
            BUSY  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (ADDR == LAST_ADDR) begin
            state     <= ST_DRAIN;
            ADDR      <= '0;
            EN        <= 1'b0;
            drain_cnt <= 1'b0;
          end else begin
            ADDR <= ADDR + 1'b1;
          end
        end
        ST_DRAIN: begin
          // Two cycles let the last pair pass the read and multiply stages.
          if (drain_cnt) begin
            state <= ST_FINISH;
            Y     <= y_next;
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // MAC pipeline: read data is valid the cycle after EN, product one later.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      p_vld <= 1'b0;
      prod  <= '0;
      acc   <= '0;
    end else begin
      p_vld <= EN;
      if (EN) begin
        prod <= PROD_W'(w_s) * PROD_W'(x_s);
      end
      if ((state == ST_IDLE) && START) begin
        acc <= '0;
      end else if (p_vld) begin
        acc <= acc + ACC_W'(prod);
      end
    end
  end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Bench for neuron_mac_seq: a RELU=1 and a RELU=0 instance, each with its
// own pair of BRAM models (falling-edge read) over shared memory contents.
module tb_neuron_mac_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start;
  logic [15:0] bias;

  logic [4:0]  addr_r, addr_l;
  logic        en_r, en_l, we_r, we_l;
  logic [15:0] w_do_r, x_do_r, w_do_l, x_do_l;
  logic [15:0] y_r, y_l;
  logic        busy_r, busy_l, done_r, done_l;
  nn_pkg::nn_state_e st_r, st_l;

  logic [15:0] w_mem [32];
  logic [15:0] x_mem [32];

  int n_vec = 0;
  int n_err = 0;

  neuron_mac_seq #(.RELU(1)) u_relu (
    .CLK(clk), .RST(rst), .START(start), .ADDR(addr_r), .EN(en_r), .WE(we_r),
    .W_DO(w_do_r), .X_DO(x_do_r), .BIAS(bias), .Y(y_r), .BUSY(busy_r),
    .DONE(done_r), .STATE_DBG(st_r)
  );

  neuron_mac_seq #(.RELU(0)) u_lin (
    .CLK(clk), .RST(rst), .START(start), .ADDR(addr_l), .EN(en_l), .WE(we_l),
    .W_DO(w_do_l), .X_DO(x_do_l), .BIAS(bias), .Y(y_l), .BUSY(busy_l),
    .DONE(done_l), .STATE_DBG(st_l)
  );

  // BRAM models: read on the falling edge when enabled
  always @(negedge clk) begin
    if (en_r) begin
      w_do_r <= w_mem[addr_r];
      x_do_r <= x_mem[addr_r];
    end
    if (en_l) begin
      w_do_l <= w_mem[addr_l];
      x_do_l <= x_mem[addr_l];
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer dot product, bias in Q.16, floor, clamp, ReLU
  function automatic logic [15:0] ref_y(input logic [15:0] b, input bit relu);
    longint s;
    s = 0;
    for (int i = 0; i < 28; i++) begin
      s += longint'($signed(w_mem[i])) * longint'($signed(x_mem[i]));
    end
    s += longint'($signed(b)) * 256;
    s = s >>> 8;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return s[15:0];
  endfunction

  // ---------------- drivers ----------------
  task automatic fill(input logic [15:0] w, input logic [15:0] x);
    for (int i = 0; i < 32; i++) begin
      w_mem[i] = (i < 28) ? w : 16'h1234;
      x_mem[i] = (i < 28) ? x : 16'h1234;
    end
  endtask

  // Pulse START, then count edges until DONE on the RELU instance
  task automatic run_eval(input logic [15:0] b, output int lat, output int busy_n);
    bias = b;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    busy_n = 0;
    while (!done_r && lat < 60) begin
      if (busy_r) busy_n++;
      @(posedge clk); #1 lat++;
    end
  endtask

  typedef struct {
    logic [15:0] w;
    logic [15:0] x;
    logic [15:0] b;
    logic [15:0] exp_relu;
    logic [15:0] exp_lin;
  } vec_t;

  vec_t tbl [7];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int lat, busy_n, dones;
    logic [15:0] y_hold;

    tbl[0] = '{16'h0100, 16'h0100, 16'h0000, 16'h1C00, 16'h1C00};
    tbl[1] = '{16'hFF00, 16'h0100, 16'h0000, 16'h0000, 16'hE400};
    tbl[2] = '{16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h7FFF};
    tbl[3] = '{16'h8000, 16'h7FFF, 16'h0000, 16'h0000, 16'h8000};
    tbl[4] = '{16'h0000, 16'h4321, 16'h0280, 16'h0280, 16'h0280};
    tbl[5] = '{16'h0080, 16'h0001, 16'h0000, 16'h000E, 16'h000E};
    tbl[6] = '{16'h0001, 16'h0001, 16'hFFFF, 16'h0000, 16'hFFFF};

    rst = 1'b1;
    start = 1'b0;
    bias = 16'h0000;
    fill(16'h0000, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {en_r, we_r, busy_r, done_r, en_l, busy_l, done_l, 9'd0, addr_r},
          32'd0);
    check("reset_y", {y_r, y_l}, 32'd0);
    check("reset_state", 32'(st_r), 32'(nn_pkg::ST_IDLE));
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Table-driven directed vectors
    for (int t = 0; t < 7; t++) begin
      fill(tbl[t].w, tbl[t].x);
      run_eval(tbl[t].b, lat, busy_n);
      check($sformatf("latency[%0d]", t), 32'(lat), 32'd30);
      check($sformatf("busy_cycles[%0d]", t), 32'(busy_n), 32'd30);
      check($sformatf("done_busy[%0d]", t), {28'd0, done_r, done_l, busy_r, busy_l}, 32'hC);
      check($sformatf("y_relu[%0d]", t), 32'(y_r), 32'(tbl[t].exp_relu));
      check($sformatf("y_lin[%0d]", t), 32'(y_l), 32'(tbl[t].exp_lin));
      y_hold = y_r;
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("done_pulse_hold[%0d]", t), {15'd0, done_r, y_r}, {16'd0, y_hold});
    end

    // Address monitor, START during RUN, START on the DONE edge
    fill(16'h0100, 16'h0100);
    bias = 16'h0000;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 28; k++) begin
      check($sformatf("addr_mon[%0d]", k), {24'd0, en_r, we_r, addr_r}, {24'd0, 1'b1, 1'b0, 5'(k)});
      start = (k == 5);
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("addr_after_run", {26'd0, en_r, we_r, addr_r[3:0]}, 32'd0);
    check("addr_after_run_hi", 32'(addr_r), 32'd0);
    lat = 28;
    while (!done_r && lat < 60) begin
      start = (lat == 29);
      @(posedge clk); #1 lat++;
    end
    start = 1'b0;
    check("mon_latency", 32'(lat), 32'd30);
    check("mon_y", {y_r, y_l}, 32'h1C001C00);
    dones = 0;
    busy_n = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done_r || done_l) dones++;
      if (busy_r || busy_l || en_r) busy_n++;
    end
    check("ignored_starts_done", 32'(dones), 32'd0);
    check("ignored_starts_busy", 32'(busy_n), 32'd0);

    // Asynchronous reset in the middle of RUN
    fill(16'h0200, 16'h0100);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrun_rst_ctrl", {28'd0, en_r, busy_r, en_l, busy_l}, 32'd0);
    check("midrun_rst_y", {y_r, y_l}, 32'd0);
    check("midrun_rst_addr", 32'(addr_r), 32'd0);
    #1 rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done_r || done_l || busy_r) dones++;
    end
    check("midrun_no_done", 32'(dones), 32'd0);
    fill(16'h0100, 16'h0100);
    run_eval(16'h0000, lat, busy_n);
    check("post_rst_latency", 32'(lat), 32'd30);
    check("post_rst_y", {y_r, y_l}, 32'h1C001C00);

    // Randomized vectors against the reference model
    for (int r = 0; r < 10; r++) begin
      logic [15:0] b;
      logic [15:0] e_r, e_l;
      for (int i = 0; i < 28; i++) begin
        if (r % 2 == 0) begin
          w_mem[i] = 16'($urandom_range(0, 65535));
          x_mem[i] = 16'($urandom_range(0, 65535));
        end else begin
          w_mem[i] = 16'($urandom_range(0, 1023)) - 16'd512;
          x_mem[i] = 16'($urandom_range(0, 1023)) - 16'd512;
        end
      end
      b = 16'($urandom_range(0, 65535));
      e_r = ref_y(b, 1'b1);
      e_l = ref_y(b, 1'b0);
      run_eval(b, lat, busy_n);
      check($sformatf("rand_latency[%0d]", r), 32'(lat), 32'd30);
      check($sformatf("rand_y_relu[%0d]", r), 32'(y_r), 32'(e_r));
      check($sformatf("rand_y_lin[%0d]", r), 32'(y_l), 32'(e_l));
      repeat (2) @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
